// File: rtl/beat_sequencer_if.sv
// Beat bus between the beat sequencer and the hardwired controller.
//
// The sequencer drives the beat vector W[3:1], RUN and MCYC_END (plus CYC_CNT when the
// CYCLE_CNT_EN macro is defined). The controller returns SHORT, LONG and STOP.
//
// Modports:
//   master - beat sequencer side
//   slave  - controller side
interface beat_sequencer_if
`ifdef CYCLE_CNT_EN
#(
  parameter int unsigned CNT_W = 16
)
`endif
();
  logic [2:0] W;
  logic       RUN;
  logic       MCYC_END;
  logic       SHORT;
  logic       LONG;
  logic       STOP;
`ifdef CYCLE_CNT_EN
  logic [CNT_W-1:0] CYC_CNT;
`endif

`ifdef CYCLE_CNT_EN
  modport master (
    output W, RUN, MCYC_END, CYC_CNT,
    input  SHORT, LONG, STOP
  );
  modport slave (
    input  W, RUN, MCYC_END, CYC_CNT,
    output SHORT, LONG, STOP
  );
`else
  modport master (
    output W, RUN, MCYC_END,
    input  SHORT, LONG, STOP
  );
  modport slave (
    input  W, RUN, MCYC_END,
    output SHORT, LONG, STOP
  );
`endif
endinterface

// File: rtl/beat_sequencer.sv
// Beat sequencer for the hardwired controller.
//
// Produces the W[3:1] beats of one machine cycle (1, 2 or 3 beats) as steered by the
// controller's SHORT/LONG requests, chains cycles back-to-back unless STOP or single-step
// (DP) is seen at the end of a cycle, and handles the asynchronous start button QD.
//
// Ports:
//   T3    - clock, all state updates on the rising edge
//   CLR   - synchronous active-high reset, overrides everything
//   QD    - start button, asynchronous level
//   DP    - single-step: halt after every machine cycle
//   ctl   - beat bus (master): W, RUN, MCYC_END, [CYC_CNT] out; SHORT, LONG, STOP in
//
// Parameters:
//   QD_SYNC_STAGES - synchronizer depth on QD (minimum 2)
//   CNT_W          - machine-cycle counter width (only with CYCLE_CNT_EN)
//
// Optional feature: define CYCLE_CNT_EN to add the completed machine-cycle counter CYC_CNT.
module beat_sequencer #(
  parameter int unsigned QD_SYNC_STAGES = 2
`ifdef CYCLE_CNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             T3,
  input  logic             CLR,
  input  logic             QD,
  input  logic             DP,
  beat_sequencer_if.master ctl
);

  // State encoding doubles as the registered beat vector.
  typedef enum logic [2:0] {
    StIdle = 3'b000,
    StB1   = 3'b001,
    StB2   = 3'b010,
    StB3   = 3'b100
  } state_e;

  state_e state_q, state_d;
  logic   mcyc_end;

  // ---------------------------------------------------------------------------
  // Start button: synchronizer, arming and rising-edge detection
  // ---------------------------------------------------------------------------
  logic [QD_SYNC_STAGES-1:0] qd_sync_q, qd_sync_d;
  // Marks which synchronizer stages hold real samples of QD since the last CLR.
  logic [QD_SYNC_STAGES-1:0] qd_vld_q, qd_vld_d;
  logic                      qd_prev_q, qd_prev_d;
  logic                      qd_armed_q, qd_armed_d;
  logic                      qd_s;
  logic                      qd_pulse;

  assign qd_s = qd_sync_q[QD_SYNC_STAGES-1];

  always_comb begin
    qd_sync_d = {qd_sync_q[QD_SYNC_STAGES-2:0], QD};
    qd_vld_d  = {qd_vld_q[QD_SYNC_STAGES-2:0], 1'b1};
    qd_prev_d = qd_s;
    // A button held through CLR must be released before it can start the machine, so the
    // detector only arms once a genuine low has come out of the synchronizer.
    qd_armed_d = qd_armed_q | (qd_vld_q[QD_SYNC_STAGES-1] & ~qd_s);
    qd_pulse   = qd_armed_q & qd_s & ~qd_prev_q;
  end

  always_ff @(posedge T3) begin
    if (CLR) begin
      qd_sync_q  <= '0;
      qd_vld_q   <= '0;
      qd_prev_q  <= 1'b0;
      qd_armed_q <= 1'b0;
    end else begin
      qd_sync_q  <= qd_sync_d;
      qd_vld_q   <= qd_vld_d;
      qd_prev_q  <= qd_prev_d;
      qd_armed_q <= qd_armed_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Beat FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = StIdle;
    mcyc_end = 1'b0;
    case (state_q)
      StIdle: state_d = qd_pulse ? StB1 : StIdle;
      StB1: begin
        // SHORT wins over LONG; LONG is only looked at in B2.
        if (ctl.SHORT) mcyc_end = 1'b1;
        else           state_d  = StB2;
      end
      StB2: begin
        if (ctl.LONG) state_d  = StB3;
        else          mcyc_end = 1'b1;
      end
      StB3:    mcyc_end = 1'b1;
      default: state_d  = StIdle;  // multi-hot or otherwise illegal encoding
    endcase
    // End of machine cycle: STOP/DP only matter here; otherwise chain with no gap beat.
    if (mcyc_end) begin
      state_d = (ctl.STOP || DP) ? StIdle : StB1;
    end
  end

  always_ff @(posedge T3) begin
    if (CLR) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign ctl.W        = state_q;
  assign ctl.RUN      = (state_q != StIdle);
  assign ctl.MCYC_END = mcyc_end;

  // ---------------------------------------------------------------------------
  // Completed machine-cycle counter
  // ---------------------------------------------------------------------------
`ifdef CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (mcyc_end) cyc_cnt_d = cyc_cnt_q + CNT_W'(1);  // wraps silently
  end

  always_ff @(posedge T3) begin
    if (CLR) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end

  assign ctl.CYC_CNT = cyc_cnt_q;
`endif

endmodule

// File: tb/tb_beat_sequencer.sv
// Self-checking bench for beat_sequencer. Each scenario builds a per-cycle plan of inputs
// with the expected MCYC_END for that cycle and the expected W after the following edge;
// expected W (and CYC_CNT) are queued when the inputs are driven and popped after the edge.
module tb_beat_sequencer;

  typedef struct packed {
    logic       clr;
    logic       qd;
    logic       dp;
    logic       sh;
    logic       lg;
    logic       st;
    logic       mc;
    logic [2:0] w;
  } vec_t;

  logic T3 = 1'b0;
  logic CLR;
  logic QD;
  logic DP;

  int checks = 0;
  int passes = 0;

  vec_t       plan[$];
  logic [2:0] w_q[$];
`ifdef CYCLE_CNT_EN
  logic [15:0] cnt_q[$];
  logic [15:0] exp_cnt = '0;
`endif

  beat_sequencer_if bus ();

  beat_sequencer dut (
    .T3  (T3),
    .CLR (CLR),
    .QD  (QD),
    .DP  (DP),
    .ctl (bus)
  );

  always #5 T3 = ~T3;

  function automatic vec_t mk(input logic clr, input logic qd, input logic dp,
                              input logic sh, input logic lg, input logic st,
                              input logic mc, input logic [2:0] w);
    mk = '{clr, qd, dp, sh, lg, st, mc, w};
  endfunction

  task automatic add(input vec_t x, input int n = 1);
    for (int i = 0; i < n; i++) plan.push_back(x);
  endtask

  // Apply one cycle of stimulus and queue the results expected after the next edge.
  task automatic drive(input vec_t v);
    CLR       = v.clr;
    QD        = v.qd;
    DP        = v.dp;
    bus.SHORT = v.sh;
    bus.LONG  = v.lg;
    bus.STOP  = v.st;
    w_q.push_back(v.w);
`ifdef CYCLE_CNT_EN
    if (v.clr)     exp_cnt = '0;
    else if (v.mc) exp_cnt = exp_cnt + 16'd1;
    cnt_q.push_back(exp_cnt);
`endif
  endtask

  task automatic test_reset();
    vec_t       v;
    logic [2:0] ew;
    int         row;
`ifdef CYCLE_CNT_EN
    logic [15:0] ec;
`endif
    CLR = 1'b1; QD = 1'b1; DP = 1'b1;
    bus.SHORT = 1'b1; bus.LONG = 1'b0; bus.STOP = 1'b0;
    @(posedge T3); #1;
    add(mk(1, 1, 1, 1, 0, 0, 0, 3'b000));      // second CLR edge
    add(mk(0, 1, 1, 1, 0, 0, 0, 3'b000), 6);   // QD still held: must not start
    add(mk(0, 0, 1, 1, 0, 0, 0, 3'b000), 4);
    add(mk(0, 1, 1, 1, 0, 0, 0, 3'b000), 2);   // fresh press
    add(mk(0, 1, 1, 1, 0, 0, 0, 3'b001));
    add(mk(0, 0, 1, 1, 0, 0, 1, 3'b000));
    add(mk(0, 0, 1, 1, 0, 0, 0, 3'b000), 3);
    row = 0;
    while (plan.size() > 0) begin
      v = plan.pop_front();
      drive(v);
      #1;
      checks++;
      if (bus.MCYC_END !== v.mc)
        $display("FAIL reset.mcyc_end row %0d: got %b want %b", row, bus.MCYC_END, v.mc);
      else passes++;
      @(posedge T3); #1;
      ew = w_q.pop_front();
      checks++;
      if (bus.W !== ew) $display("FAIL reset.w row %0d: got %b want %b", row, bus.W, ew);
      else passes++;
      checks++;
      if (bus.RUN !== (ew != 3'b000))
        $display("FAIL reset.run row %0d: got %b want %b", row, bus.RUN, ew != 3'b000);
      else passes++;
`ifdef CYCLE_CNT_EN
      ec = cnt_q.pop_front();
      checks++;
      if (bus.CYC_CNT !== ec)
        $display("FAIL reset.cyc_cnt row %0d: got %0d want %0d", row, bus.CYC_CNT, ec);
      else passes++;
`endif
      row++;
    end
  endtask

  task automatic test_single_step();
    vec_t       v;
    logic [2:0] ew;
    int         row;
`ifdef CYCLE_CNT_EN
    logic [15:0] ec;
`endif
    add(mk(0, 1, 1, 0, 0, 0, 0, 3'b000), 2);
    add(mk(0, 1, 1, 0, 0, 0, 0, 3'b001));
    add(mk(0, 1, 1, 0, 0, 0, 0, 3'b010));
    add(mk(0, 1, 1, 0, 0, 0, 1, 3'b000));      // end in W2, DP halts
    add(mk(0, 0, 1, 0, 0, 0, 0, 3'b000), 3);
    row = 0;
    while (plan.size() > 0) begin
      v = plan.pop_front();
      drive(v);
      #1;
      checks++;
      if (bus.MCYC_END !== v.mc)
        $display("FAIL step.mcyc_end row %0d: got %b want %b", row, bus.MCYC_END, v.mc);
      else passes++;
      @(posedge T3); #1;
      ew = w_q.pop_front();
      checks++;
      if (bus.W !== ew) $display("FAIL step.w row %0d: got %b want %b", row, bus.W, ew);
      else passes++;
      checks++;
      if (bus.RUN !== (ew != 3'b000))
        $display("FAIL step.run row %0d: got %b want %b", row, bus.RUN, ew != 3'b000);
      else passes++;
`ifdef CYCLE_CNT_EN
      ec = cnt_q.pop_front();
      checks++;
      if (bus.CYC_CNT !== ec)
        $display("FAIL step.cyc_cnt row %0d: got %0d want %0d", row, bus.CYC_CNT, ec);
      else passes++;
`endif
      row++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t       v;
    logic [2:0] ew;
    int         row;
`ifdef CYCLE_CNT_EN
    logic [15:0] ec;
`endif
    add(mk(0, 1, 0, 0, 1, 0, 0, 3'b000), 2);
    add(mk(0, 1, 0, 0, 1, 0, 0, 3'b001));
    for (int k = 0; k < 2; k++) begin
      add(mk(0, 0, 0, 0, 1, 0, 0, 3'b010));
      add(mk(0, 0, 0, 0, 1, 0, 0, 3'b100));
      add(mk(0, 0, 0, 0, 1, 0, 1, 3'b001));    // chains with no idle beat
    end
    add(mk(0, 0, 0, 0, 1, 1, 0, 3'b010));      // STOP mid-cycle does not truncate
    add(mk(0, 0, 0, 0, 1, 1, 0, 3'b100));
    add(mk(0, 0, 0, 0, 1, 1, 1, 3'b000));
    add(mk(0, 0, 0, 0, 0, 0, 0, 3'b000), 3);
    row = 0;
    while (plan.size() > 0) begin
      v = plan.pop_front();
      drive(v);
      #1;
      checks++;
      if (bus.MCYC_END !== v.mc)
        $display("FAIL b2b.mcyc_end row %0d: got %b want %b", row, bus.MCYC_END, v.mc);
      else passes++;
      @(posedge T3); #1;
      ew = w_q.pop_front();
      checks++;
      if (bus.W !== ew) $display("FAIL b2b.w row %0d: got %b want %b", row, bus.W, ew);
      else passes++;
      checks++;
      if (bus.RUN !== (ew != 3'b000))
        $display("FAIL b2b.run row %0d: got %b want %b", row, bus.RUN, ew != 3'b000);
      else passes++;
`ifdef CYCLE_CNT_EN
      ec = cnt_q.pop_front();
      checks++;
      if (bus.CYC_CNT !== ec)
        $display("FAIL b2b.cyc_cnt row %0d: got %0d want %0d", row, bus.CYC_CNT, ec);
      else passes++;
`endif
      row++;
    end
  endtask

  task automatic test_short_stop();
    vec_t       v;
    logic [2:0] ew;
    int         row;
`ifdef CYCLE_CNT_EN
    logic [15:0] ec;
`endif
    add(mk(0, 1, 0, 1, 1, 0, 0, 3'b000), 2);
    add(mk(0, 1, 0, 1, 1, 0, 0, 3'b001));
    add(mk(0, 0, 0, 1, 1, 0, 1, 3'b001), 3);   // SHORT beats LONG: 1-beat cycles
    add(mk(0, 0, 0, 1, 1, 1, 1, 3'b000));      // STOP in 4th W1
    add(mk(0, 0, 0, 0, 0, 0, 0, 3'b000), 3);
    row = 0;
    while (plan.size() > 0) begin
      v = plan.pop_front();
      drive(v);
      #1;
      checks++;
      if (bus.MCYC_END !== v.mc)
        $display("FAIL short.mcyc_end row %0d: got %b want %b", row, bus.MCYC_END, v.mc);
      else passes++;
      @(posedge T3); #1;
      ew = w_q.pop_front();
      checks++;
      if (bus.W !== ew) $display("FAIL short.w row %0d: got %b want %b", row, bus.W, ew);
      else passes++;
      checks++;
      if (bus.RUN !== (ew != 3'b000))
        $display("FAIL short.run row %0d: got %b want %b", row, bus.RUN, ew != 3'b000);
      else passes++;
`ifdef CYCLE_CNT_EN
      ec = cnt_q.pop_front();
      checks++;
      if (bus.CYC_CNT !== ec)
        $display("FAIL short.cyc_cnt row %0d: got %0d want %0d", row, bus.CYC_CNT, ec);
      else passes++;
`endif
      row++;
    end
  endtask

  task automatic test_clr_mid_cycle();
    vec_t       v;
    logic [2:0] ew;
    int         row;
`ifdef CYCLE_CNT_EN
    logic [15:0] ec;
`endif
    add(mk(0, 1, 0, 0, 1, 0, 0, 3'b000), 2);
    add(mk(0, 1, 0, 0, 1, 0, 0, 3'b001));
    add(mk(0, 0, 0, 0, 1, 0, 0, 3'b010));
    add(mk(1, 0, 0, 0, 1, 0, 0, 3'b000));      // CLR in W2
    add(mk(0, 0, 0, 0, 0, 0, 0, 3'b000), 4);
    add(mk(0, 1, 1, 1, 0, 0, 0, 3'b000), 2);   // second press restarts
    add(mk(0, 1, 1, 1, 0, 0, 0, 3'b001));
    add(mk(0, 0, 1, 1, 0, 0, 1, 3'b000));
    add(mk(0, 0, 0, 0, 0, 0, 0, 3'b000), 3);
    row = 0;
    while (plan.size() > 0) begin
      v = plan.pop_front();
      drive(v);
      #1;
      checks++;
      if (bus.MCYC_END !== v.mc)
        $display("FAIL clr.mcyc_end row %0d: got %b want %b", row, bus.MCYC_END, v.mc);
      else passes++;
      @(posedge T3); #1;
      ew = w_q.pop_front();
      checks++;
      if (bus.W !== ew) $display("FAIL clr.w row %0d: got %b want %b", row, bus.W, ew);
      else passes++;
      checks++;
      if (bus.RUN !== (ew != 3'b000))
        $display("FAIL clr.run row %0d: got %b want %b", row, bus.RUN, ew != 3'b000);
      else passes++;
`ifdef CYCLE_CNT_EN
      ec = cnt_q.pop_front();
      checks++;
      if (bus.CYC_CNT !== ec)
        $display("FAIL clr.cyc_cnt row %0d: got %0d want %0d", row, bus.CYC_CNT, ec);
      else passes++;
`endif
      row++;
    end
  endtask

  task automatic test_qd_while_run();
    vec_t       v;
    logic [2:0] ew;
    int         row;
`ifdef CYCLE_CNT_EN
    logic [15:0] ec;
`endif
    add(mk(0, 1, 1, 0, 1, 0, 0, 3'b000), 2);
    add(mk(0, 0, 1, 0, 1, 0, 0, 3'b001));
    add(mk(0, 1, 1, 0, 1, 0, 0, 3'b010));      // re-press while running
    add(mk(0, 1, 1, 0, 1, 0, 0, 3'b100));
    add(mk(0, 1, 1, 0, 1, 0, 1, 3'b000));      // its pulse lands in W3: dropped
    add(mk(0, 1, 1, 0, 1, 0, 0, 3'b000), 4);
    add(mk(0, 0, 1, 0, 0, 0, 0, 3'b000), 4);
    add(mk(0, 1, 1, 1, 0, 0, 0, 3'b000), 2);   // fresh press
    add(mk(0, 1, 1, 1, 0, 0, 0, 3'b001));
    add(mk(0, 0, 1, 1, 0, 0, 1, 3'b000));
    add(mk(0, 0, 0, 0, 0, 0, 0, 3'b000), 2);
    row = 0;
    while (plan.size() > 0) begin
      v = plan.pop_front();
      drive(v);
      #1;
      checks++;
      if (bus.MCYC_END !== v.mc)
        $display("FAIL qdrun.mcyc_end row %0d: got %b want %b", row, bus.MCYC_END, v.mc);
      else passes++;
      @(posedge T3); #1;
      ew = w_q.pop_front();
      checks++;
      if (bus.W !== ew) $display("FAIL qdrun.w row %0d: got %b want %b", row, bus.W, ew);
      else passes++;
      checks++;
      if (bus.RUN !== (ew != 3'b000))
        $display("FAIL qdrun.run row %0d: got %b want %b", row, bus.RUN, ew != 3'b000);
      else passes++;
`ifdef CYCLE_CNT_EN
      ec = cnt_q.pop_front();
      checks++;
      if (bus.CYC_CNT !== ec)
        $display("FAIL qdrun.cyc_cnt row %0d: got %0d want %0d", row, bus.CYC_CNT, ec);
      else passes++;
`endif
      row++;
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_back_to_back();
    test_short_stop();
    test_clr_mid_cycle();
    test_qd_while_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
